// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: scheduler state encoding,
// parity-type codes, byte width and a small index wrap helper.
package uart_pkg;

   localparam int UART_DW = 8;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [1:0] {
      UART_SCHED_IDLE      = 2'd0,
      UART_SCHED_ISSUE     = 2'd1,
      UART_SCHED_WAIT_DONE = 2'd2,
      UART_SCHED_GAP       = 2'd3
   } uart_sched_state_t;

   // Wraps an index in [0, 2n-1] back into [0, n-1] without a divider.
   function automatic int rr_wrap(input int v, input int n);
      return (v >= n) ? (v - n) : v;
   endfunction

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin picker: first requester after last_owner, wrapping.
// Kept standalone so other arbiters on the UART path can share it.
module rr_pick
   import uart_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last_owner,
   output logic            valid,
   output logic [IW-1:0]   idx
);

   logic [NREQ-1:0] rot;
   logic [IW-1:0]   cand [NREQ];

   // cand[gi] is the requester at distance gi+1 from the last owner.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
      assign cand[gi] = IW'(rr_wrap(int'(last_owner) + 1 + gi, NREQ));
      assign rot[gi]  = req[cand[gi]];
   end

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            valid = 1'b1;
            idx   = cand[i];
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART TX serializer among NREQ byte sources.
// Captures the winner's byte and parity setup, holds them for the frame, then idles GAP_CYC cycles.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int GAP_CYC = 2,
   parameter int TO_CYC  = 4096
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [UART_DW*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]         req_par_en,
   input  logic [NREQ-1:0]         req_par_typ,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         done,
   output logic                    err,
   output logic                    busy,
   output logic                    tx_start,
   output logic [UART_DW-1:0]      tx_data,
   output logic                    par_en,
   output logic                    par_typ,
   input  logic                    tx_busy,
   input  logic                    tx_done
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TO_CYC);
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);
   localparam uart_sched_state_t POST_FRAME = (GAP_CYC == 0) ? UART_SCHED_IDLE : UART_SCHED_GAP;

   uart_sched_state_t state_reg, state_next;
   logic [IW-1:0]      owner_reg, owner_next;
   logic [IW-1:0]      last_reg, last_next;
   logic [CW-1:0]      cnt_reg, cnt_next;
   logic [GW-1:0]      gap_reg, gap_next;
   logic [UART_DW-1:0] tx_data_reg, tx_data_next;
   logic               par_en_reg, par_en_next;
   logic               par_typ_reg, par_typ_next;
   logic [NREQ-1:0]    gnt_reg, gnt_next;
   logic [NREQ-1:0]    done_reg, done_next;
   logic               err_reg, err_next;
   logic               busy_reg, busy_next;
   logic               tx_start_reg, tx_start_next;

   logic               pick_valid;
   logic [IW-1:0]      pick_idx;
   logic [NREQ-1:0]    pick_oh;
   logic [NREQ-1:0]    owner_oh;
   logic [UART_DW-1:0] req_byte [NREQ];

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req        (req),
      .last_owner (last_reg),
      .valid      (pick_valid),
      .idx        (pick_idx)
   );

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_dec
      assign req_byte[gi] = req_data[gi*UART_DW +: UART_DW];
      assign pick_oh[gi]  = (pick_idx == IW'(gi));
      assign owner_oh[gi] = (owner_reg == IW'(gi));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= UART_SCHED_IDLE;
         owner_reg    <= '0;
         last_reg     <= LAST_RST;
         cnt_reg      <= '0;
         gap_reg      <= '0;
         tx_data_reg  <= '0;
         par_en_reg   <= 1'b0;
         par_typ_reg  <= PAR_EVEN;
         gnt_reg      <= '0;
         done_reg     <= '0;
         err_reg      <= 1'b0;
         busy_reg     <= 1'b0;
         tx_start_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         owner_reg    <= owner_next;
         last_reg     <= last_next;
         cnt_reg      <= cnt_next;
         gap_reg      <= gap_next;
         tx_data_reg  <= tx_data_next;
         par_en_reg   <= par_en_next;
         par_typ_reg  <= par_typ_next;
         gnt_reg      <= gnt_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
         busy_reg     <= busy_next;
         tx_start_reg <= tx_start_next;
      end
   end

   // cnt_reg equals the number of cycles since the tx_start cycle, so a
   // tx_done seen with cnt_reg == TO_CYC-1 still wins over the timeout.
   always_comb begin
      state_next    = state_reg;
      owner_next    = owner_reg;
      last_next     = last_reg;
      cnt_next      = cnt_reg;
      gap_next      = gap_reg;
      tx_data_next  = tx_data_reg;
      par_en_next   = par_en_reg;
      par_typ_next  = par_typ_reg;
      gnt_next      = '0;
      done_next     = '0;
      err_next      = 1'b0;
      tx_start_next = 1'b0;

      case (state_reg)
         UART_SCHED_IDLE: begin
            if (pick_valid && !tx_busy) begin
               owner_next    = pick_idx;
               tx_data_next  = req_byte[pick_idx];
               par_en_next   = req_par_en[pick_idx];
               par_typ_next  = req_par_typ[pick_idx];
               gnt_next      = pick_oh;
               tx_start_next = 1'b1;
               cnt_next      = '0;
               state_next    = UART_SCHED_ISSUE;
            end
         end
         UART_SCHED_ISSUE: begin
            cnt_next   = cnt_reg + 1'b1;
            state_next = UART_SCHED_WAIT_DONE;
         end
         UART_SCHED_WAIT_DONE: begin
            cnt_next = cnt_reg + 1'b1;
            if (tx_done) begin
               done_next  = owner_oh;
               last_next  = owner_reg;
               gap_next   = '0;
               state_next = POST_FRAME;
            end else if (cnt_reg == CW'(TO_CYC - 1)) begin
               err_next   = 1'b1;
               last_next  = owner_reg;
               gap_next   = '0;
               state_next = POST_FRAME;
            end
         end
         UART_SCHED_GAP: begin
            gap_next = gap_reg + 1'b1;
            if (gap_reg == GW'(GAP_CYC - 1)) begin
               state_next = UART_SCHED_IDLE;
            end
         end
         default: state_next = UART_SCHED_IDLE;
      endcase

      busy_next = (state_next != UART_SCHED_IDLE);
   end

   assign gnt      = gnt_reg;
   assign done     = done_reg;
   assign err      = err_reg;
   assign busy     = busy_reg;
   assign tx_start = tx_start_reg;
   assign tx_data  = tx_data_reg;
   assign par_en   = par_en_reg;
   assign par_typ  = par_typ_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: a frame-level reference model predicts
// grant/start/done/err events with their cycle numbers; a monitor checks every cycle.
module tb_uart_tx_sched;
   import uart_pkg::*;

   localparam int NREQ    = 4;
   localparam int GAP_CYC = 2;
   localparam int TO_CYC  = 128;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [NREQ-1:0]       req = '0;
   logic [8*NREQ-1:0]     req_data = '0;
   logic [NREQ-1:0]       req_par_en = '0;
   logic [NREQ-1:0]       req_par_typ = '0;
   logic [NREQ-1:0]       gnt, done;
   logic                  err, busy, tx_start, par_en, par_typ;
   logic [7:0]            tx_data;
   logic                  tx_busy;
   logic                  tx_done = 1'b0;
   logic                  ser_busy = 1'b0;
   logic                  stall = 1'b0;

   assign tx_busy = ser_busy | stall;

   uart_tx_sched #(
      .NREQ    (NREQ),
      .GAP_CYC (GAP_CYC),
      .TO_CYC  (TO_CYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_data    (req_data),
      .req_par_en  (req_par_en),
      .req_par_typ (req_par_typ),
      .gnt         (gnt),
      .done        (done),
      .err         (err),
      .busy        (busy),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .par_en      (par_en),
      .par_typ     (par_typ),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              cyc;
      logic [NREQ-1:0] gnt;
      logic            start;
      logic [NREQ-1:0] done;
      logic            err;
      logic [7:0]      data;
      logic            pe;
      logic            pt;
   } ev_t;

   ev_t q[$];
   int  len_q[$];
   int  n_checks = 0;
   int  n_fail = 0;
   int  cyc = 0;
   int  rst_cyc = -1;
   int  busy_last = -10;
   int  frame_start = 0;
   int  m_last = NREQ - 1;
   int  cur_len = 1;
   bit  ser_reset = 1'b0;
   bit  late_pulse = 1'b0;
   bit  drop_on_gnt = 1'b0;

   int         start_cyc[$];
   int         start_idx[$];
   logic [7:0] start_data[$];
   int         done_cyc[$];
   logic [7:0] done_data[$];
   logic       done_pt[$];
   int         err_cyc[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic int oh2i(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Reference model: decides at each edge whether a frame starts and, if so,
   // who wins and when the frame's done or err must appear.
   initial begin
      int  w;
      int  len;
      ev_t e;
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst) begin
            q.delete();
            m_last      = NREQ - 1;
            busy_last   = cyc - 1;
            frame_start = cyc;
            rst_cyc     = cyc;
         end else if (cyc >= busy_last + 2 && !tx_busy && req != 0) begin
            w = -1;
            for (int j = 1; j <= NREQ && w < 0; j++)
               if (req[(m_last + j) % NREQ]) w = (m_last + j) % NREQ;
            if (len_q.size() > 0) len = len_q.pop_front();
            else len = $urandom_range(1, 40);
            cur_len = len;
            e.cyc   = cyc;
            e.gnt   = '0;
            e.gnt[w] = 1'b1;
            e.start = 1'b1;
            e.done  = '0;
            e.err   = 1'b0;
            e.data  = req_data[w*8 +: 8];
            e.pe    = req_par_en[w];
            e.pt    = req_par_typ[w];
            q.push_back(e);
            if (len <= TO_CYC - 1) begin
               e.cyc  = cyc + len + 1;
               e.done = e.gnt;
            end else begin
               e.cyc = cyc + TO_CYC;
               e.err = 1'b1;
            end
            e.gnt   = '0;
            e.start = 1'b0;
            q.push_back(e);
            frame_start = cyc;
            busy_last   = e.cyc + GAP_CYC - 1;
            m_last      = w;
         end
      end
   end

   // Serializer model: tx_done cur_len cycles after tx_start, or a late pulse after a timeout.
   initial begin
      int done_at = -1;
      int abort_at = -1;
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (ser_reset) begin
            ser_busy  = 1'b0;
            done_at   = -1;
            abort_at  = -1;
            ser_reset = 1'b0;
         end
         if (tx_start === 1'b1) begin
            ser_busy = 1'b1;
            if (cur_len < TO_CYC) done_at = cyc + cur_len;
            else abort_at = cyc + TO_CYC;
         end else if (done_at == cyc) begin
            tx_done  = 1'b1;
            ser_busy = 1'b0;
            done_at  = -1;
         end else if (abort_at == cyc) begin
            tx_done  = 1'b1;
            ser_busy = 1'b0;
            abort_at = -1;
         end
         if (late_pulse) begin
            tx_done    = 1'b1;
            late_pulse = 1'b0;
         end
      end
   end

   // Monitor: pops the scoreboard when an event is due, otherwise demands silence.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (cyc == rst_cyc) begin
            check("reset_state", {gnt, done, err, busy, tx_start, tx_data, par_en, par_typ}, 64'd0);
         end else if (cyc > 0) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
               check("event_time", cyc, q[0].cyc);
               void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
               e = q.pop_front();
               check(e.start ? "frame_issue" : "frame_end",
                     {gnt, tx_start, done, err, tx_data, par_en, par_typ},
                     {e.gnt, e.start, e.done, e.err, e.data, e.pe, e.pt});
            end else begin
               check("quiet", {gnt, tx_start, done, err}, 64'd0);
            end
            check("busy", busy, (cyc >= frame_start && cyc <= busy_last));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      if (tx_start === 1'b1) begin
         start_cyc.push_back(cyc);
         start_idx.push_back(oh2i(gnt));
         start_data.push_back(tx_data);
      end
      if (done != '0) begin
         done_cyc.push_back(cyc);
         done_data.push_back(tx_data);
         done_pt.push_back(par_typ);
      end
      if (err === 1'b1) err_cyc.push_back(cyc);
      if (drop_on_gnt) req = req & ~gnt;
   endtask

   task automatic clear_logs();
      start_cyc.delete(); start_idx.delete(); start_data.delete();
      done_cyc.delete(); done_data.delete(); done_pt.delete(); err_cyc.delete();
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (!(req == '0 && q.size() == 0 && cyc > busy_last) && n < budget) begin
         tick();
         n++;
      end
      check("idle_reached", n < budget, 1);
   endtask

   task automatic wait_starts(input int cnt, input int budget);
      int n = 0;
      while (start_cyc.size() < cnt && n < budget) begin
         tick();
         n++;
      end
      check("start_seen", start_cyc.size() >= cnt, 1);
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   initial begin
      int t0;
      #500000;
      $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      int t0;
      repeat (3) tick();
      rst = 1'b1;
      tick();

      // Single request: latency, captured byte, long frame.
      clear_logs();
      req_data[7:0] = 8'hA5; req_par_en[0] = 1'b1; req_par_typ[0] = PAR_EVEN;
      len_q.push_back(110);
      drop_on_gnt = 1'b1;
      t0 = cyc;
      req = 4'b0001;
      wait_idle(400);
      check("p1_frames", start_cyc.size(), 1);
      if (start_cyc.size() > 0 && done_cyc.size() > 0) begin
         check("p1_latency", start_cyc[0], t0 + 1);
         check("p1_owner", start_idx[0], 0);
         check("p1_done_time", done_cyc[0], start_cyc[0] + 111);
      end

      // All held high: fair rotation and frame spacing.
      pulse_reset();
      clear_logs();
      for (int k = 0; k < NREQ; k++) req_data[k*8 +: 8] = 8'h10 + 8'(k);
      repeat (6) len_q.push_back(20);
      drop_on_gnt = 1'b0;
      req = 4'b1111;
      wait_starts(6, 300);
      req = 4'b0000;
      wait_idle(200);
      for (int i = 0; i < 6 && i < start_idx.size(); i++) begin
         check("p2_order", start_idx[i], i % NREQ);
         check("p2_data", start_data[i], 8'h10 + 8'(i % NREQ));
         if (i > 0) check("p2_spacing", start_cyc[i] - start_cyc[i-1], 20 + 2 + GAP_CYC);
      end

      // Priority after requester 2 was served last.
      drop_on_gnt = 1'b1;
      req = 4'b0100;
      wait_idle(200);
      clear_logs();
      req = 4'b0101;
      wait_idle(300);
      check("p3_frames", start_idx.size(), 2);
      if (start_idx.size() >= 2) begin
         check("p3_first", start_idx[0], 0);
         check("p3_second", start_idx[1], 2);
      end

      // Timeout, then done arriving on the very last allowed cycle.
      clear_logs();
      len_q.push_back(TO_CYC);
      len_q.push_back(TO_CYC - 1);
      req = 4'b0011;
      wait_idle(3 * TO_CYC);
      check("p4_err_count", err_cyc.size(), 1);
      check("p4_done_count", done_cyc.size(), 1);
      if (err_cyc.size() > 0 && done_cyc.size() > 0 && start_cyc.size() >= 2) begin
         check("p4_err_time", err_cyc[0] - start_cyc[0], TO_CYC);
         check("p4_next_owner", start_idx[1], 1);
         check("p4_done_time", done_cyc[0] - start_cyc[1], TO_CYC);
      end

      // Inputs change mid-frame; captured byte and parity must hold.
      clear_logs();
      req_data[7:0] = 8'h55; req_par_en[0] = 1'b1; req_par_typ[0] = PAR_EVEN;
      len_q.push_back(30);
      req = 4'b0001;
      wait_starts(1, 50);
      repeat (5) tick();
      req_data[7:0] = 8'h00; req_par_typ[0] = PAR_ODD;
      wait_idle(200);
      check("p5_done_count", done_data.size(), 1);
      if (done_data.size() > 0) begin
         check("p5_held_data", done_data[0], 8'h55);
         check("p5_held_par", done_pt[0], PAR_EVEN);
      end

      // Reset during WAIT_DONE, then a late tx_done, then requester 3.
      clear_logs();
      len_q.push_back(60);
      req = 4'b0010;
      wait_starts(1, 50);
      repeat (10) tick();
      ser_reset = 1'b1;
      pulse_reset();
      clear_logs();
      late_pulse = 1'b1;
      repeat (2) tick();
      req = 4'b1000;
      wait_idle(200);
      check("p6_frames", start_idx.size(), 1);
      check("p6_no_done", done_cyc.size(), 1);
      if (start_idx.size() > 0) check("p6_owner", start_idx[0], 3);

      // Randomized traffic: withdrawals, held requests, stalls, timeouts.
      drop_on_gnt = 1'b0;
      for (int n = 0; n < 2500; n++) begin
         tick();
         for (int k = 0; k < NREQ; k++) begin
            if (req[k] && gnt[k]) begin
               if ($urandom_range(0, 3) != 0) req[k] = 1'b0;
            end else if (req[k]) begin
               if ($urandom_range(0, 39) == 0) req[k] = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
               req_data[k*8 +: 8] = 8'($urandom);
               req_par_en[k]  = 1'($urandom);
               req_par_typ[k] = 1'($urandom);
               req[k] = 1'b1;
            end
         end
         stall = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 15) == 0)
            len_q.push_back(($urandom_range(0, 4) == 0) ? TO_CYC : int'($urandom_range(1, TO_CYC - 1)));
      end
      req = '0;
      stall = 1'b0;
      len_q.delete();
      wait_idle(3 * TO_CYC);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART transmit serializer between NREQ requesters. It captures one byte per grant, together with that requester's parity configuration. It drives the serializer's start/data/parity inputs and holds them stable for the whole frame. It enforces an inter-frame gap and flags serializer timeouts. It sits between the host-side message sources and the single TX frame engine, the companion of the RX frame engine.

Parameters:
NREQ, 4, number of requesters (2..8)
GAP_CYC, 2, idle clock cycles inserted after each frame (0 allowed)
TO_CYC, 4096, max cycles from tx_start to tx_done before timeout (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
req  in  NREQ  per-requester request, level
req_data  in  8*NREQ  byte of requester k on bits [8k+7:8k]
req_par_en  in  NREQ  parity enable of requester k
req_par_typ  in  NREQ  parity type of requester k (0 even, 1 odd)
gnt  out  NREQ  one-hot one-cycle pulse: byte of owner captured
done  out  NREQ  one-hot one-cycle pulse: owner's frame finished
err  out  1  one-cycle pulse: frame timed out
busy  out  1  high whenever state != IDLE
tx_start  out  1  one-cycle start strobe to serializer
tx_data  out  8  byte to serializer
par_en  out  1  parity enable to serializer
par_typ  out  1  parity type to serializer
tx_busy  in  1  serializer busy
tx_done  in  1  serializer one-cycle frame-complete pulse

Behaviour:
- Reset (rst==0 at posedge): state IDLE. gnt, done, err, busy, tx_start, tx_data, par_en and par_typ all 0. last_owner = NREQ-1, so requester 0 has first priority. Counters 0. Reset mid-frame aborts silently, with no done and no err.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE:
  - Arbitrates only if |req and tx_busy==0.
  - Winner is the first k with req[k]==1, scanning last_owner+1, last_owner+2, ... modulo NREQ.
  - On the clock edge: owner <= k; tx_data, par_en and par_typ latch from requester k; state <= ISSUE.
- ISSUE (exactly 1 cycle):
  - tx_start=1 and gnt[owner]=1 in this same cycle.
  - Timeout counter cleared.
  - Next state WAIT_DONE.
- WAIT_DONE:
  - tx_data, par_en and par_typ held constant. Changes on req or req_* inputs are ignored.
  - Counter increments each cycle.
  - If tx_done==1: done[owner] pulses next cycle; last_owner <= owner; go to GAP.
  - Else if counter == TO_CYC-1: err pulses next cycle, done does not pulse; last_owner <= owner; go to GAP.
  - tx_done has priority when it arrives on the timeout cycle.
- GAP: stays GAP_CYC cycles, then goes to IDLE. GAP_CYC==0 means go straight from WAIT_DONE to IDLE.
- Latency: req rises in IDLE, serializer idle: sampled at edge t, gnt and tx_start high in cycle t+1.
- Throughput: one frame per (serializer frame time + 2 + GAP_CYC) cycles.
- Requester contract:
  - Data and parity inputs must be stable while req is high.
  - The requester may drop req the cycle after gnt. A req still high after gnt is treated as a new request.
- req dropping before being granted: withdrawn with no side effects.
- tx_done outside WAIT_DONE is ignored.
- tx_busy high in IDLE stalls arbitration; no starvation bookkeeping changes.
- Fairness: with all req held high, grants go 0,1,2,...,NREQ-1,0,... Each requester waits at most NREQ-1 frames.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings UART_SCHED_IDLE/ISSUE/WAIT_DONE/GAP (2-bit);
  - PAR_EVEN=0, PAR_ODD=1;
  - the byte width constant UART_DW=8.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req[NREQ], last_owner.
  - Outputs: valid, idx.
  - Reused by future RX-buffer drain arbitration.

Test Plan:
- Reset, then req=4'b0001, data0=8'hA5, par_en0=1, par_typ0=0:
  - one cycle later tx_start=1, gnt=4'b0001, tx_data=8'hA5, par_en=1, par_typ=0;
  - tx_done after 110 cycles, then done=4'b0001 next cycle, busy low after 2 GAP cycles.
- req=4'b1111 held, data k=8'h10+k, model tx_done 20 cycles after tx_start:
  - grant order 0,1,2,3,0,1;
  - tx_data 8'h10,11,12,13,10,11;
  - spacing between tx_start pulses = 20+1+1+2 = 24 cycles.
- req=4'b0101 after requester 2 served last: next grant is requester 0, then requester 2.
- TO_CYC=16, model never asserts tx_done: err pulses exactly at tx_start+16, done stays 0, next requester then granted.
- Mid-frame (WAIT_DONE), change data0 to 8'h00 and par_typ0 to 1: tx_data and par_typ stay unchanged until done.
- rst=0 asserted during WAIT_DONE:
  - next cycle all outputs 0 and state IDLE;
  - req=4'b1000 then granted to requester 3;
  - a late tx_done is ignored.
